// File: rtl/readout_sequencer.sv
// ---------------------------------------------------------------------------
// readout_sequencer
//
// Frame readout controller for the pixel array. A frame begins on `start` and
// visits every pixel in row-major order. For each pixel the sequencer lets the
// row and column lines settle, then requests one ADC conversion over a
// sample_req/sample_ack handshake. It drives the control inputs of two one-hot
// selector stages: a row selector of length ROWS and a column selector of
// length COLS.
//
// Parameters:
//   ROWS          number of rows    (>= 2, equals the row selector length)
//   COLS          number of columns (>= 2, equals the column selector length)
//   SETTLE_CYCLES settle wait after a row or column change (>= 1)
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-low reset
//   start        begin a frame; only looked at in IDLE
//   sample_ack   ADC conversion done; only looked at while sample_req = 1
//   busy         high in every state except IDLE
//   done         one-cycle pulse when the frame completes
//   row_advance  row selector inputEnable  (shift to next row)
//   row_enable   row selector outputEnable
//   row_restart  row selector reset        (active-high pulse)
//   col_advance  column selector inputEnable
//   col_enable   column selector outputEnable
//   col_restart  column selector reset     (active-high pulse)
//   sample_req   conversion request to the ADC
//   row_idx      current row number, binary
//   col_idx      current column number, binary
//
// Every output is a flop. The output flops are loaded with the decode of the
// next state, so each output equals the decode of the state it belongs to and
// no input ever reaches an output combinationally.
// ---------------------------------------------------------------------------
module readout_sequencer #(
  parameter int unsigned ROWS          = 4,
  parameter int unsigned COLS          = 4,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      sample_ack,
  output logic                      busy,
  output logic                      done,
  output logic                      row_advance,
  output logic                      row_enable,
  output logic                      row_restart,
  output logic                      col_advance,
  output logic                      col_enable,
  output logic                      col_restart,
  output logic                      sample_req,
  output logic [$clog2(ROWS)-1:0]   row_idx,
  output logic [$clog2(COLS)-1:0]   col_idx
);

  localparam int unsigned RW    = $clog2(ROWS);
  localparam int unsigned CW    = $clog2(COLS);
  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);

  // Terminal values are compared explicitly so the indices never wrap.
  localparam logic [RW-1:0]    ROW_LAST    = RW'(ROWS - 1);
  localparam logic [CW-1:0]    COL_LAST    = CW'(COLS - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESTART,
    ST_ROW_SETTLE,
    ST_COL_SETTLE,
    ST_SAMPLE,
    ST_NEXT_COL,
    ST_NEXT_ROW,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic busy;
    logic done;
    logic row_advance;
    logic row_enable;
    logic row_restart;
    logic col_advance;
    logic col_enable;
    logic col_restart;
    logic sample_req;
  } outs_t;

  state_e           state_q,  state_d;
  logic [CNT_W-1:0] settle_q, settle_d;
  logic [RW-1:0]    row_q,    row_d;
  logic [CW-1:0]    col_q,    col_d;
  outs_t            outs_q,   outs_d;

  // Moore output decode: each state owns a fixed set of asserted controls,
  // everything else is 0.
  function automatic outs_t decode(input state_e s);
    outs_t o;
    o      = '0;
    o.busy = (s != ST_IDLE);
    case (s)
      ST_RESTART: begin
        o.row_restart = 1'b1;
        o.col_restart = 1'b1;
      end
      ST_ROW_SETTLE: begin
        o.row_enable = 1'b1;
      end
      ST_COL_SETTLE: begin
        o.row_enable = 1'b1;
        o.col_enable = 1'b1;
      end
      ST_SAMPLE: begin
        o.row_enable = 1'b1;
        o.col_enable = 1'b1;
        o.sample_req = 1'b1;
      end
      ST_NEXT_COL: begin
        o.row_enable  = 1'b1;
        o.col_advance = 1'b1;
      end
      ST_NEXT_ROW: begin
        o.row_advance = 1'b1;
        o.col_restart = 1'b1;
      end
      ST_DONE: begin
        o.done = 1'b1;
      end
      default: ;
    endcase
    return o;
  endfunction

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis would infer a latch to hold it.
    state_d  = state_q;
    settle_d = settle_q;
    row_d    = row_q;
    col_d    = col_q;

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RESTART;
      end

      ST_RESTART: begin
        row_d    = '0;
        col_d    = '0;
        settle_d = '0;
        state_d  = ST_ROW_SETTLE;
      end

      // The settle counter starts at 0 on entry and the state is left in the
      // cycle the counter reads SETTLE_CYCLES-1, giving SETTLE_CYCLES cycles.
      ST_ROW_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          settle_d = '0;
          state_d  = ST_COL_SETTLE;
        end else begin
          settle_d = settle_q + CNT_W'(1);
        end
      end

      ST_COL_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          settle_d = '0;
          state_d  = ST_SAMPLE;
        end else begin
          settle_d = settle_q + CNT_W'(1);
        end
      end

      // An ack in the very first SAMPLE cycle completes the transfer, so a
      // pixel can be converted with zero wait states.
      ST_SAMPLE: begin
        if (sample_ack) begin
          if (col_q < COL_LAST)      state_d = ST_NEXT_COL;
          else if (row_q < ROW_LAST) state_d = ST_NEXT_ROW;
          else                       state_d = ST_DONE;
        end
      end

      ST_NEXT_COL: begin
        col_d    = col_q + CW'(1);
        settle_d = '0;
        state_d  = ST_COL_SETTLE;
      end

      ST_NEXT_ROW: begin
        row_d    = row_q + RW'(1);
        col_d    = '0;
        settle_d = '0;
        state_d  = ST_ROW_SETTLE;
      end

      // Indices keep their last values until the next RESTART.
      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    outs_d = decode(state_d);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples values from before the edge, independent of statement order.
    if (!reset) begin
      state_q  <= ST_IDLE;
      settle_q <= '0;
      row_q    <= '0;
      col_q    <= '0;
      outs_q   <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      row_q    <= row_d;
      col_q    <= col_d;
      outs_q   <= outs_d;
    end
  end

  assign busy        = outs_q.busy;
  assign done        = outs_q.done;
  assign row_advance = outs_q.row_advance;
  assign row_enable  = outs_q.row_enable;
  assign row_restart = outs_q.row_restart;
  assign col_advance = outs_q.col_advance;
  assign col_enable  = outs_q.col_enable;
  assign col_restart = outs_q.col_restart;
  assign sample_req  = outs_q.sample_req;
  assign row_idx     = row_q;
  assign col_idx     = col_q;

endmodule

// File: tb/tb_readout_sequencer.sv
// ---------------------------------------------------------------------------
// tb_readout_sequencer
//
// Scoreboard bench for readout_sequencer (ROWS = COLS = 4, SETTLE_CYCLES = 2).
// Before each frame a reference model lays out the frame timeline from the
// readout rules: every pixel in row-major order, the cycle its request rises,
// the cycle its handshake completes, and the cycle `done` pulses. A monitor
// compares what the DUT presents against those queues. An ADC responder
// acknowledges either continuously or after a per-pixel delay taken from the
// same delay table the model uses. Two behavioural one-hot selectors follow
// the DUT's selector controls.
// ---------------------------------------------------------------------------
module tb_readout_sequencer;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int S    = 2;
  localparam int NPIX = ROWS * COLS;
  localparam int RW   = $clog2(ROWS);
  localparam int CW   = $clog2(COLS);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          sample_ack = 1'b0;
  logic          busy, done, row_advance, row_enable, row_restart;
  logic          col_advance, col_enable, col_restart, sample_req;
  logic [RW-1:0] row_idx;
  logic [CW-1:0] col_idx;
  logic [8:0]    outs;

  readout_sequencer #(.ROWS(ROWS), .COLS(COLS), .SETTLE_CYCLES(S)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .sample_ack (sample_ack),
    .busy       (busy),
    .done       (done),
    .row_advance(row_advance),
    .row_enable (row_enable),
    .row_restart(row_restart),
    .col_advance(col_advance),
    .col_enable (col_enable),
    .col_restart(col_restart),
    .sample_req (sample_req),
    .row_idx    (row_idx),
    .col_idx    (col_idx)
  );

  assign outs = {busy, done, row_advance, row_enable, row_restart,
                 col_advance, col_enable, col_restart, sample_req};

  always #5 clk = ~clk;

  // Number of rising edges so far; read half a cycle or 1 ns after an edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int r;
    int c;
    int req_c;
    int hs_c;
  } exp_t;

  exp_t exp_q[$];
  int   done_q[$];
  int   dly[NPIX];
  bit   ack_tied = 1'b1;

  // Frame timeline from the readout rules, counted from the cycle `start` is
  // presented (t0): RESTART 1 cycle, row settle S, column settle S, then
  // SAMPLE for delay+1 cycles. A column step costs NEXT_COL + S settle, a row
  // step costs NEXT_ROW + 2*S settle, the last pixel is followed by DONE.
  task automatic predict(input int t0, output int dc);
    int   t;
    exp_t e;
    t = t0 + 2 + 2 * S;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        e.r     = r;
        e.c     = c;
        e.req_c = t;
        e.hs_c  = t + dly[r * COLS + c];
        exp_q.push_back(e);
        if (c < COLS - 1) t = e.hs_c + 2 + S;
        else              t = e.hs_c + 2 + 2 * S;
      end
    end
    dc = e.hs_c + 1;
    done_q.push_back(dc);
  endtask

  // ---------------- ADC responder ----------------
  int pix     = 0;
  int waited  = 0;
  bit hs_pend = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (row_restart) begin
        pix     = 0;
        waited  = 0;
        hs_pend = 1'b0;
      end else if (hs_pend) begin
        pix++;
        waited  = 0;
        hs_pend = 1'b0;
      end
      if (ack_tied) begin
        sample_ack = 1'b1;
      end else if (sample_req && pix < NPIX) begin
        sample_ack = (waited == dly[pix]);
        hs_pend    = sample_ack;
        waited++;
      end else begin
        sample_ack = 1'b0;
      end
    end
  end

  // ---------------- behavioural one-hot selectors ----------------
  logic [ROWS-1:0] row_sel = '0;
  logic [COLS-1:0] col_sel = '0;
  logic [COLS-1:0] col_out;

  always @(posedge clk) begin
    if (row_restart)      row_sel <= ROWS'(1);
    else if (row_advance) row_sel <= row_sel << 1;
    if (col_restart)      col_sel <= COLS'(1);
    else if (col_advance) col_sel <= col_sel << 1;
  end

  assign col_out = col_enable ? col_sel : '0;

  // ---------------- monitor ----------------
  exp_t mon_e;
  int   mon_d;
  int   req_start = 0;
  logic req_prev = 1'b0, ra_prev = 1'b0, ca_prev = 1'b0;
  logic rr_prev = 1'b0, cr_prev = 1'b0;

  always @(negedge clk) begin
    if (sample_req) begin
      if (!req_prev) req_start = cyc;
      check("req_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        check("row_idx", 32'(row_idx), 32'(exp_q[0].r));
        check("col_idx", 32'(col_idx), 32'(exp_q[0].c));
        check("sample_ctrl", 32'(outs), 32'(9'b100100101));
        if (sample_ack) begin
          mon_e = exp_q.pop_front();
          check("req_rise_cycle", 32'(req_start), 32'(mon_e.req_c));
          check("handshake_cycle", 32'(cyc), 32'(mon_e.hs_c));
        end
      end
    end
    if (done) begin
      check("done_expected", 32'(done_q.size() > 0), 32'd1);
      if (done_q.size() > 0) begin
        mon_d = done_q.pop_front();
        check("done_cycle", 32'(cyc), 32'(mon_d));
        check("done_busy", 32'(busy), 32'd1);
      end
    end
    if (row_advance || col_advance)
      check("advance_exclusive", 32'(row_advance && col_advance), 32'd0);
    if (row_advance) check("row_advance_width", 32'(ra_prev), 32'd0);
    if (col_advance) check("col_advance_width", 32'(ca_prev), 32'd0);
    if (row_restart) check("row_restart_width", 32'(rr_prev), 32'd0);
    if (col_restart) check("col_restart_width", 32'(cr_prev), 32'd0);
    if (row_enable)  check("row_selector", 32'(row_sel), 32'(ROWS'(1) << row_idx));
    if (col_enable)  check("col_selector", 32'(col_out), 32'(COLS'(1) << col_idx));
    req_prev = sample_req;
    ra_prev  = row_advance;
    ca_prev  = col_advance;
    rr_prev  = row_restart;
    cr_prev  = col_restart;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input bit hold, output int t0, output int dc);
    t0 = cyc;
    predict(t0, dc);
    start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    while ((exp_q.size() > 0 || done_q.size() > 0) && n < 3000) begin
      tick();
      n++;
    end
    check("frame_drained", 32'(exp_q.size() + done_q.size()), 32'd0);
    exp_q.delete();
    done_q.delete();
    tick();
    check("idle_after_frame", 32'(outs), 32'd0);
  endtask

  task automatic set_delays(input int lo, input int hi);
    for (int k = 0; k < NPIX; k++) dly[k] = (lo == hi) ? lo : int'($urandom_range(hi, lo));
  endtask

  int  t0, dc, dc2;
  bit  found;

  initial begin
    set_delays(0, 0);

    // Reset state, with the ADC acknowledging continuously.
    repeat (3) tick();
    check("reset_outputs", 32'(outs), 32'd0);
    check("reset_row_idx", 32'(row_idx), 32'd0);
    check("reset_col_idx", 32'(col_idx), 32'd0);
    reset = 1'b1;
    repeat (3) tick();
    check("idle_ack_ignored", 32'(outs), 32'd0);

    // Ack tied high across IDLE and settle states: nominal frame timing.
    launch(1'b0, t0, dc);
    wait_frame();

    // Start pulses mid-frame must be ignored.
    launch(1'b0, t0, dc);
    while (cyc < t0 + 10) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    while (cyc < t0 + 40) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_frame();
    repeat (10) tick();
    check("no_relaunch", 32'(busy), 32'd0);

    // Every ack delayed by 5 cycles.
    ack_tied = 1'b0;
    set_delays(5, 5);
    launch(1'b0, t0, dc);
    wait_frame();

    // Random ack delays.
    for (int f = 0; f < 3; f++) begin
      set_delays(0, 5);
      launch(1'b0, t0, dc);
      wait_frame();
    end

    // Start held high through DONE: a second frame follows from IDLE.
    set_delays(0, 3);
    launch(1'b1, t0, dc);
    predict(dc + 1, dc2);
    while (cyc < dc + 2) tick();
    start = 1'b0;
    wait_frame();

    // Reset while pixel (2,1) is being sampled.
    set_delays(0, 4);
    dly[2 * COLS + 1] = 7;
    launch(1'b0, t0, dc);
    found = 1'b0;
    for (int n = 0; n < 2000 && !found; n++) begin
      tick();
      if (sample_req && row_idx == RW'(2) && col_idx == CW'(1)) found = 1'b1;
    end
    check("reached_pixel_2_1", 32'(found), 32'd1);
    reset = 1'b0;
    tick();
    check("midframe_reset_outputs", 32'(outs), 32'd0);
    check("midframe_reset_row_idx", 32'(row_idx), 32'd0);
    check("midframe_reset_col_idx", 32'(col_idx), 32'd0);
    exp_q.delete();
    done_q.delete();
    reset = 1'b1;
    ack_tied = 1'b1;
    set_delays(0, 0);
    tick();
    launch(1'b0, t0, dc);
    check("restart_after_reset", 32'(outs), 32'(9'b100010010));
    wait_frame();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected < 50000", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/readout_sequencer.md
# readout_sequencer

Frame readout controller for the pixel array. On `start` it walks every pixel in row-major order by driving the control inputs of two one-hot `Selector` stages: a row selector (`length = ROWS`) and a column selector (`length = COLS`). At each pixel it waits a programmable settle time, then requests one ADC conversion over a req/ack handshake. It is the stage directly upstream of the selectors and owns their advance, enable and restart signals.

## Interface
Parameters:
- `ROWS`, default 4: number of rows; must be ≥ 2; must equal the row selector `length`.
- `COLS`, default 4: number of columns; must be ≥ 2; must equal the column selector `length`.
- `SETTLE_CYCLES`, default 2: wait after a row or column change before sampling; must be ≥ 1.

Ports (one clock; reset is synchronous and active-low):
- `clk` input 1: system clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-low reset.
- `start` input 1: begin a frame; sampled only in IDLE.
- `sample_ack` input 1: ADC conversion done; honoured only while `sample_req` = 1.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse when the frame completes.
- `row_advance` output 1: to row selector `inputEnable`.
- `row_enable` output 1: to row selector `outputEnable`.
- `row_restart` output 1: to row selector `reset` (active-high pulse).
- `col_advance` output 1: to column selector `inputEnable`.
- `col_enable` output 1: to column selector `outputEnable`.
- `col_restart` output 1: to column selector `reset` (active-high pulse).
- `sample_req` output 1: conversion request to the ADC.
- `row_idx` output $clog2(ROWS): current row number, binary.
- `col_idx` output $clog2(COLS): current column number, binary.

## Operation
- Moore FSM. All outputs decode from registered state and counters only; no input reaches an output combinationally.
- States: IDLE, RESTART, ROW_SETTLE, COL_SETTLE, SAMPLE, NEXT_COL, NEXT_ROW, DONE.
- IDLE: `start` = 1 → RESTART.
- RESTART: lasts 1 cycle.
  - Outputs: `row_restart` = `col_restart` = 1.
  - Clears `row_idx` and `col_idx` to 0, then → ROW_SETTLE.
- ROW_SETTLE: lasts SETTLE_CYCLES cycles.
  - Outputs: `row_enable` = 1.
  - → COL_SETTLE.
- COL_SETTLE: lasts SETTLE_CYCLES cycles.
  - Outputs: `row_enable` = `col_enable` = 1.
  - → SAMPLE.
- SAMPLE: `row_enable` = `col_enable` = `sample_req` = 1; holds until `sample_ack` = 1.
  - `col_idx` < COLS-1 → NEXT_COL.
  - `col_idx` = COLS-1 and `row_idx` < ROWS-1 → NEXT_ROW.
  - Last pixel → DONE.
- NEXT_COL: lasts 1 cycle.
  - Outputs: `row_enable` = `col_advance` = 1.
  - Increments `col_idx`, then → COL_SETTLE.
- NEXT_ROW: lasts 1 cycle.
  - Outputs: `row_advance` = `col_restart` = 1.
  - Increments `row_idx`, clears `col_idx` to 0, then → ROW_SETTLE.
- DONE: lasts 1 cycle.
  - Outputs: `done` = 1.
  - Indices hold their last values, then → IDLE.
- Settle counter:
  - Width $clog2(SETTLE_CYCLES+1).
  - Loads 0 on entry to either settle state and counts up.
  - Exits on the cycle it reads SETTLE_CYCLES-1.
- Indices never wrap. Terminal values are detected explicitly.
- Every output not listed for a state is 0.

## Timing
- Reset, when `reset` = 0 at a rising edge:
  - State → IDLE.
  - All outputs 0; `row_idx` = `col_idx` = 0; settle counter 0.
  - The same applies when reset hits mid-frame. The next frame must start with RESTART.
- `start` takes effect at the edge where it is sampled; RESTART occupies the next cycle.
- `start` while `busy` = 1 is ignored.
- `start` held high after DONE launches a new frame from IDLE 1 cycle later.
- Handshake:
  - A transfer completes in the cycle where `sample_req` = `sample_ack` = 1.
  - `sample_req` drops the next cycle.
  - An ack is accepted in the first SAMPLE cycle, giving zero wait states.
  - `sample_ack` outside SAMPLE has no effect.
- Pixel cost with ack tied high:
  - Within a row: 2 + SETTLE_CYCLES cycles (NEXT_COL, COL_SETTLE, SAMPLE).
  - Row change: 2 + 2·SETTLE_CYCLES cycles.
- Worked frame: ROWS = COLS = 4, SETTLE_CYCLES = 2, ack tied high, `start` sampled at edge 0.
  - `busy` is high in cycles 1–73; `done` is high in cycle 73; IDLE from cycle 74.
  - Per-pixel timing is given in Test plan 1.
- Advance and restart pulses are exactly 1 cycle wide. `row_advance` and `col_advance` are never high together.

## Test plan
1. Reset, ack tied high, ROWS = COLS = 4, S = 2, `start` pulsed once → `sample_req` highs:
   - Pixel (0,0) in cycle 6.
   - Pixel (0,1) in cycle 10.
   - Pixel (1,0) in cycle 24.
   - 16 handshakes in total; `done` in cycle 73.
2. Ack delayed 5 cycles on every request → `sample_req` is held for 6 cycles each time. Indices and selector controls are stable while it is held. The frame still ends with exactly 16 handshakes.
3. Reset asserted in SAMPLE of pixel (2,1) → next cycle all outputs are 0 and indices are 0. A following `start` produces `row_restart` before any sampling.
4. `start` pulsed in cycles 10 and 40 of a frame → no effect; exactly one `done` pulse.
5. `sample_ack` held high across IDLE and the settle states → it is only consumed in SAMPLE, and the per-pixel cycle counts match scenario 1.
6. Selector co-simulation: after each `row_advance`, the row selector's one-hot output equals 1 << `row_idx`. The same holds for the column selector and `col_idx`, with its output gated by `col_enable`.
